// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the MEM-stage data-memory interface. Each load/store is
//   served from an internal word RAM after a fixed latency. memStall freezes
//   the pipeline while an access is in flight, memAck marks completion.
// Parameters
//   ADDR_W   word-address width; RAM depth = 2**ADDR_W 32-bit words
//   LATENCY  cycles memStall is held per access (1..15)
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   memRead      in   load request
//   memWrite     in   store request (wins when both are high)
//   address      in   byte address; word index = address[ADDR_W+1:2]
//   writeData    in   store data
//   readData     out  load data, valid with memAck for a read; held otherwise
//   memStall     out  combinational pipeline hold
//   memAck       out  one-cycle completion pulse
//   misalignErr  out  one-cycle pulse with memAck when address[1:0]!=0
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        memStall,
  output logic        memAck,
  output logic        misalignErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The accept cycle is the first stall cycle, so BUSY lasts LATENCY-1 cycles.
  localparam logic [3:0] CNT_LOAD = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic              wr_q, rd_q, mis_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;

  logic [31:0] ram [2**ADDR_W];

  logic              req;
  logic [ADDR_W-1:0] idx_live;
  logic              mis_live;
  logic              unused_addr_bits;

  assign req              = memRead | memWrite;
  assign idx_live         = address[ADDR_W+1:2];
  assign mis_live         = |address[1:0];
  assign unused_addr_bits = ^address[31:ADDR_W+2];

  // Read data is registered on the edge that enters DONE. With LATENCY==1
  // that edge is the accept edge itself, so the live request is used there.
  logic              rd_is, rd_mis, rd_load;
  logic [ADDR_W-1:0] rd_idx;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    memStall    = 1'b0;
    memAck      = 1'b0;
    misalignErr = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          memStall   = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        memStall = 1'b1;
        if (cnt == 4'd0) state_next = DONE;
        else             cnt_next   = cnt - 4'd1;
      end
      DONE: begin
        memAck      = 1'b1;
        misalignErr = mis_q;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      memStall    = 1'b0;
      memAck      = 1'b0;
      misalignErr = 1'b0;
      state_next  = IDLE;
      cnt_next    = '0;
    end
  end

  always_comb begin
    rd_is   = (state == IDLE) ? (memRead & ~memWrite) : rd_q;
    rd_mis  = (state == IDLE) ? mis_live : mis_q;
    rd_idx  = (state == IDLE) ? idx_live : idx_q;
    rd_load = (state != DONE) && (state_next == DONE) && rd_is;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      readData <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      mis_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && req) begin
        wr_q    <= memWrite;
        rd_q    <= memRead & ~memWrite;
        mis_q   <= mis_live;
        idx_q   <= idx_live;
        wdata_q <= writeData;
      end
      if (rd_load) readData <= rd_mis ? '0 : ram[rd_idx];
    end
  end

  // RAM is never cleared; a write commits on the edge that ends DONE.
  always_ff @(posedge clk) begin
    if (!rst && state == DONE && wr_q && !mis_q) ram[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: LATENCY=3, instance 1: LATENCY=1
  logic        rst_a, rd_a, wr_a, stall_a, ack_a, mis_a;
  logic [31:0] addr_a, wd_a, rdata_a;
  logic        rst_b, rd_b, wr_b, stall_b, ack_b, mis_b;
  logic [31:0] addr_b, wd_b, rdata_b;

  data_mem_responder #(.ADDR_W(10), .LATENCY(3)) dut_a (
    .clk(clk), .rst(rst_a), .memRead(rd_a), .memWrite(wr_a),
    .address(addr_a), .writeData(wd_a), .readData(rdata_a),
    .memStall(stall_a), .memAck(ack_a), .misalignErr(mis_a)
  );

  data_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst_b), .memRead(rd_b), .memWrite(wr_b),
    .address(addr_b), .writeData(wd_b), .readData(rdata_b),
    .memStall(stall_b), .memAck(ack_b), .misalignErr(mis_b)
  );

  int checks = 0;
  int errors = 0;
  int acks_a = 0;
  int acks_b = 0;

  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] ram_a [int];
  logic [31:0] ram_b [int];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expected response per memAck
  always @(negedge clk) begin
    exp_t e;
    if (ack_a === 1'b1) begin
      acks_a++;
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_ack: got memAck=1 expected no response at %0t", $time);
      end else begin
        e = qa.pop_front();
        chk("a_readData", rdata_a, e.rdata);
        chk("a_misalignErr", {31'd0, mis_a}, {31'd0, e.mis});
      end
    end
    if (ack_b === 1'b1) begin
      acks_b++;
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_ack: got memAck=1 expected no response at %0t", $time);
      end else begin
        e = qb.pop_front();
        chk("b_readData", rdata_b, e.rdata);
        chk("b_misalignErr", {31'd0, mis_b}, {31'd0, e.mis});
      end
    end
  end

  task automatic drive(input int inst, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (inst == 0) begin rd_a = r; wr_a = w; addr_a = a; wd_a = d; end
    else           begin rd_b = r; wr_b = w; addr_b = a; wd_b = d; end
  endtask

  // Push the expected response from the bench model, then issue the access and
  // check memStall/memAck/misalignErr every cycle until DONE.
  task automatic access(input int inst, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input int lat);
    exp_t e;
    logic [31:0] av;
    logic [9:0] idx10;
    int idx;
    logic mis;
    logic [31:0] st, ak, me;
    av    = a;
    idx10 = av[11:2];
    idx   = int'(idx10);
    mis   = (av[1:0] != 2'b00);
    e.mis = mis;
    if (inst == 0) begin
      if (w) begin
        if (!mis) ram_a[idx] = d;
      end else if (r) begin
        last_a = mis ? 32'd0 : (ram_a.exists(idx) ? ram_a[idx] : 32'd0);
      end
      e.rdata = last_a;
      qa.push_back(e);
    end else begin
      if (w) begin
        if (!mis) ram_b[idx] = d;
      end else if (r) begin
        last_b = mis ? 32'd0 : (ram_b.exists(idx) ? ram_b[idx] : 32'd0);
      end
      e.rdata = last_b;
      qb.push_back(e);
    end
    @(posedge clk); #1;
    drive(inst, r, w, a, d);
    for (int k = 0; k <= lat; k++) begin
      #1;
      st = {31'd0, (inst == 0) ? stall_a : stall_b};
      ak = {31'd0, (inst == 0) ? ack_a : ack_b};
      me = {31'd0, (inst == 0) ? mis_a : mis_b};
      chk($sformatf("memStall_c%0d", k), st, {31'd0, k < lat});
      chk($sformatf("memAck_c%0d", k), ak, {31'd0, k == lat});
      chk($sformatf("misalignErr_c%0d", k), me, {31'd0, (k == lat) && mis});
      @(posedge clk); #1;
    end
    drive(inst, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    rst_a = 1'b1; rst_b = 1'b1;
    // Reset state: outputs quiet even with a request on the inputs
    @(posedge clk); #1;
    drive(0, 1, 0, 32'h10, '0);
    drive(1, 0, 1, 32'h0, 32'h1);
    #1;
    chk("rst_memStall_a", {31'd0, stall_a}, 32'd0);
    chk("rst_memAck_a", {31'd0, ack_a}, 32'd0);
    chk("rst_memStall_b", {31'd0, stall_b}, 32'd0);
    @(posedge clk); #1;
    chk("rst_readData_a", rdata_a, 32'd0);
    chk("rst_misalign_a", {31'd0, mis_a}, 32'd0);
    chk("rst_readData_b", rdata_b, 32'd0);
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // 1: aligned write
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 3);
    // 2: read back, then readData holds
    access(0, 1, 0, 32'h10, '0, 3);
    idle(5); #1;
    chk("hold_readData", rdata_a, 32'hDEADBEEF);
    // Aliased address maps onto the same word
    access(0, 1, 0, 32'h1010, '0, 3);

    // 3: write held through DONE gives one ack; a new request gives another
    a0 = acks_a;
    access(0, 0, 1, 32'h40, 32'hCAFEF00D, 3);
    idle(3); #1;
    chk("single_ack", acks_a - a0, 32'd1);
    chk("idle_memStall", {31'd0, stall_a}, 32'd0);
    access(0, 0, 1, 32'h40, 32'h0BADF00D, 3);
    idle(2); #1;
    chk("second_ack", acks_a - a0, 32'd2);
    access(0, 1, 0, 32'h40, '0, 3);

    // 4: misaligned write suppressed, misaligned read returns 0
    access(0, 0, 1, 32'h13, 32'h55, 3);
    access(0, 1, 0, 32'h10, '0, 3);
    access(0, 1, 0, 32'h11, '0, 3);
    access(0, 1, 0, 32'h10, '0, 3);

    // 5: reset during BUSY drops the write
    access(0, 0, 1, 32'h20, 32'h12345678, 3);
    @(posedge clk); #1;
    drive(0, 0, 1, 32'h20, 32'h1);
    #1;
    chk("rst5_stall_accept", {31'd0, stall_a}, 32'd1);
    @(posedge clk); #1;
    rst_a = 1'b1;
    #1;
    chk("rst5_stall_inrst", {31'd0, stall_a}, 32'd0);
    chk("rst5_ack_inrst", {31'd0, ack_a}, 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    drive(0, 0, 0, '0, '0);
    last_a = '0;
    #1;
    chk("rst5_idle_stall", {31'd0, stall_a}, 32'd0);
    chk("rst5_readData", rdata_a, 32'd0);
    idle(4);
    access(0, 1, 0, 32'h20, '0, 3);

    // 6: LATENCY=1, read+write together counts as a write
    access(1, 1, 1, 32'h0, 32'hA5, 1);
    access(1, 1, 0, 32'h0, '0, 1);
    access(1, 0, 1, 32'h8, 32'h77, 1);
    access(1, 1, 0, 32'h8, '0, 1);

    idle(4);
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
